// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator and its LFSR.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 15,13,12,10), loaded with seed on reset.
module lfsr16
  import bounce_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign q    = r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_q <= seed;
    else       r_q <= {r_q[14:0], w_fb};
  end

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns a clean target level into a bouncy pin with random gaps.
// Optional idle EMI glitches are enabled by defining BOUNCE_GEN_GLITCH_EN.
module bounce_generator
  import bounce_gen_pkg::*;
#(
  parameter int          BOUNCES    = 3,
  parameter int          MIN_GAP    = 2,
  parameter int          GAP_W      = 3,
  parameter int          SETTLE_CYC = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  input  logic target,
  output logic p,
  output logic busy,
  output logic done
);

  localparam int GAP_CW = $clog2(MIN_GAP + 2**GAP_W + 1);
  localparam int TOG_W  = (BOUNCES == 0) ? 1 : $clog2(2*BOUNCES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam logic [TOG_W-1:0]  TOG_INIT = TOG_W'(2*BOUNCES);
  localparam logic [SET_W-1:0]  SET_INIT = SET_W'(SETTLE_CYC);

  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [GAP_CW-1:0] w_gap;

  state_t            r_state, w_state_nxt;
  logic              r_lvl, w_lvl_nxt;
  logic              r_p, w_p_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [GAP_CW-1:0] r_gap, w_gap_nxt;
  logic [TOG_W-1:0]  r_tog, w_tog_nxt;
  logic [SET_W-1:0]  r_set, w_set_nxt;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .seed (SEED_EFF),
    .q    (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr;
  assign w_gap = GAP_CW'(MIN_GAP) + GAP_CW'(w_lfsr[GAP_W-1:0]);

  assign p    = r_p;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (target != r_lvl) w_state_nxt = (BOUNCES == 0) ? SETTLE : BOUNCE;
      BOUNCE:  if (r_gap == GAP_CW'(1) && r_tog == TOG_W'(1)) w_state_nxt = SETTLE;
      SETTLE:  if (r_set == SET_W'(1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_lvl is the clean contact level; r_p may differ from it only during an idle glitch.
  always_comb begin
    w_lvl_nxt  = r_lvl;
    w_p_nxt    = r_lvl;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_gap_nxt  = r_gap;
    w_tog_nxt  = r_tog;
    w_set_nxt  = r_set;
    case (r_state)
      IDLE: begin
        if (target != r_lvl) begin
          w_lvl_nxt  = target;
          w_p_nxt    = target;
          w_busy_nxt = 1'b1;
          w_tog_nxt  = TOG_INIT;
          w_gap_nxt  = w_gap;
          w_set_nxt  = SET_INIT;
        end
`ifdef BOUNCE_GEN_GLITCH_EN
        else if (w_lfsr[7:0] == 8'h00 && r_p == r_lvl) begin
          w_p_nxt = ~r_lvl;
        end
`endif
      end
      BOUNCE: begin
        if (r_gap == GAP_CW'(1)) begin
          w_lvl_nxt = ~r_lvl;
          w_p_nxt   = ~r_lvl;
          w_tog_nxt = r_tog - TOG_W'(1);
          w_gap_nxt = w_gap;
          if (r_tog == TOG_W'(1)) w_set_nxt = SET_INIT;
        end else begin
          w_gap_nxt = r_gap - GAP_CW'(1);
        end
      end
      SETTLE: begin
        if (r_set == SET_W'(1)) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else begin
          w_set_nxt = r_set - SET_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lvl  <= 1'b0;
      r_p    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_gap  <= '0;
      r_tog  <= '0;
      r_set  <= '0;
    end else begin
      r_lvl  <= w_lvl_nxt;
      r_p    <= w_p_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_gap  <= w_gap_nxt;
      r_tog  <= w_tog_nxt;
      r_set  <= w_set_nxt;
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Randomised bench for bounce_generator against a schedule-building reference model.
module tb_bounce_generator;

  localparam int          B  = 3;
  localparam int          MG = 2;
  localparam int          GW = 3;
  localparam int          S  = 10;
  localparam logic [15:0] SD = 16'hACE1;
  localparam int BLEN_MIN = 2*B*MG + S;
  localparam int BLEN_MAX = 2*B*(MG + 2**GW - 1) + S;

  typedef struct packed { logic p; logic busy; logic done; } exp_t;

  logic clk = 1'b0, rstn = 1'b0, tgt = 1'b0, tgt0 = 1'b0;
  logic dp, dbusy, ddone, p0, busy0, done0;

  int n_chk = 0, n_pass = 0;

  bounce_generator #(.BOUNCES(B), .MIN_GAP(MG), .GAP_W(GW), .SETTLE_CYC(S), .SEED(SD)) dut (
    .clk(clk), .rstn(rstn), .target(tgt), .p(dp), .busy(dbusy), .done(ddone));

  bounce_generator #(.BOUNCES(0), .MIN_GAP(MG), .GAP_W(GW), .SETTLE_CYC(S), .SEED(SD)) dut0 (
    .clk(clk), .rstn(rstn), .target(tgt0), .p(p0), .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: at the start of a sequence the whole expected waveform is laid out
  // as a list of per-cycle (p, busy, done) values from the gap rule and the LFSR stream.
  exp_t        q_exp[$];
  exp_t        cur;
  logic        m_lvl;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic build(input logic tg);
    logic [15:0] lf;
    logic        lv;
    int          g;
    lf = m_lfsr;
    lv = tg;
    m_lvl = tg;
    for (int k = 0; k < 2*B; k++) begin
      g = MG + int'(lf[GW-1:0]);
      for (int j = 0; j < g; j++) begin
        q_exp.push_back('{p: lv, busy: 1'b1, done: 1'b0});
        lf = lfsr_step(lf);
      end
      lv = ~lv;
    end
    for (int j = 0; j < S; j++) q_exp.push_back('{p: tg, busy: 1'b1, done: 1'b0});
    q_exp.push_back('{p: tg, busy: 1'b0, done: 1'b1});
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lfsr = SD;
      m_lvl  = 1'b0;
      q_exp.delete();
      cur    = '0;
    end else begin
      if (q_exp.size() == 0 && tgt != m_lvl) build(tgt);
      if (q_exp.size() != 0) cur = q_exp.pop_front();
      else                   cur = '{p: m_lvl, busy: 1'b0, done: 1'b0};
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Per-sequence tracker, independent of the model: edge count, busy length, final level.
  logic prev_p = 1'b0, prev_busy = 1'b0, seq_lvl = 1'b0;
  int   ecnt = 0, blen = 0, n_done = 0;

  task automatic step();
    @(negedge clk);
    chk("p", dp, cur.p);
    chk("busy", dbusy, cur.busy);
    chk("done", ddone, cur.done);
    if (rstn) chk("lfsr", dut.u_lfsr.q, m_lfsr);
    if (dbusy && !prev_busy) begin ecnt = 0; blen = 0; seq_lvl = dp; end
    if ((dbusy || ddone) && dp != prev_p) ecnt++;
    if (dbusy) blen++;
    if (ddone) begin
      n_done++;
      chk("edges", ecnt, 2*B + 1);
      chk("final_level", dp, seq_lvl);
      chk("busy_len_ok", (blen >= BLEN_MIN && blen <= BLEN_MAX), 1);
      chk("done_after_busy", prev_busy, 1);
    end
    prev_p = dp;
    prev_busy = dbusy;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (ddone) return;
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int   k0, e0, nd;
    logic pp0;

    // Reset held for 10 cycles
    repeat (10) begin
      @(negedge clk);
      chk("rst_p", dp, 0);
      chk("rst_busy", dbusy, 0);
      chk("rst_done", ddone, 0);
    end
    chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    rstn = 1'b1;

    // First press
    repeat (3) step();
    tgt = 1'b1;
    step();
    step();
    chk("first_contact", dp, 1);
    nd = n_done;
    wait_done("press");
    chk("one_done", n_done - nd, 1);
    repeat (3) step();

    // Zero-bounce instance: single edge, done SETTLE_CYC+1 cycles after the change
    tgt0 = 1'b1;
    k0 = 0; e0 = 0; pp0 = p0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (p0 != pp0) e0++;
      pp0 = p0;
      if (k == 1) chk("b0_contact", p0, 1);
      if (done0 && k0 == 0) k0 = k;
    end
    chk("b0_done_lat", k0, S + 1);
    chk("b0_edges", e0, 1);

    // Release, then a press whose target drops back mid-bounce
    tgt = 1'b0;
    wait_done("release");
    repeat (2) step();
    tgt = 1'b1;
    repeat (4) step();
    chk("in_bounce", dbusy, 1);
    tgt = 1'b0;
    wait_done("ignore");
    chk("ignored_level", dp, 1);
    step();
    chk("restart_busy", dbusy, 1);
    chk("restart_p", dp, 0);
    wait_done("restart");

    // Async reset mid-bounce; model replays the same stimulus from reset
    tgt = 1'b1;
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    chk("abort_p", dp, 0);
    chk("abort_busy", dbusy, 0);
    chk("abort_done", ddone, 0);
    tgt = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    repeat (3) step();
    tgt = 1'b1;
    nd = n_done;
    wait_done("replay");
    chk("replay_done", n_done - nd, 1);

    // Random target activity with occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) tgt = ~tgt;
      if ($urandom_range(0, 499) == 0) begin
        #2 rstn = 1'b0;
        #1;
        chk("rnd_rst_p", dp, 0);
        chk("rnd_rst_busy", dbusy, 0);
        repeat (2) step();
        rstn = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
